// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one fixed-latency pipelined divider with tagged result routing
module div_arbiter #(
  parameter int NREQ           = 2,
  parameter int DIVIDEND_WIDTH = 17,
  parameter int DIVISOR_WIDTH  = 13,
  parameter int QUOTIENT_WIDTH = 18,
  parameter int TAG_WIDTH      = 4,
  parameter int ISSUE_INTERVAL = 4,
  parameter int LATENCY        = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ*DIVIDEND_WIDTH-1:0] req_dividend,
  input  logic [NREQ*DIVISOR_WIDTH-1:0]  req_divisor,
  input  logic [NREQ*TAG_WIDTH-1:0]      req_tag,
  output logic [DIVIDEND_WIDTH-1:0]      div_dividend,
  output logic [DIVISOR_WIDTH-1:0]       div_divisor,
  input  logic [QUOTIENT_WIDTH-1:0]      div_quotient,
  output logic [NREQ-1:0]                res_valid,
  output logic [QUOTIENT_WIDTH-1:0]      res_quotient,
  output logic [TAG_WIDTH-1:0]           res_tag,
  output logic                           busy
);
  localparam int IW = $clog2(NREQ);
  localparam int HW = ISSUE_INTERVAL > 1 ? $clog2(ISSUE_INTERVAL) : 1;
  localparam int PW = IW + TAG_WIDTH;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nxt;
  logic [HW-1:0] hcnt;
  logic [IW-1:0] rr_ptr, gid, idx;
  logic found, xfer, last, slot_free;
  logic [LATENCY:0] dv;
  logic [(LATENCY+1)*PW-1:0] dp;
  logic [PW-1:0] out_p;
  assign last      = hcnt == HW'(ISSUE_INTERVAL - 1);
  assign slot_free = state == IDLE || last;
  assign out_p     = dp[(LATENCY+1)*PW-1 -: PW];
  assign busy      = state == HOLD || |dv || |res_valid;
  // descending scan so the requester nearest rr_ptr overrides the others
  always_comb begin
    req_ready = '0;
    gid = '0;
    idx = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        gid = idx;
      end
    end
    xfer = found && slot_free && !rst;
    req_ready[gid] = xfer;
    state_nxt = xfer ? HOLD : (state == HOLD && !last) ? HOLD : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hcnt <= '0;
      rr_ptr <= '0;
      div_dividend <= '0;
      div_divisor <= '0;
      dv <= '0;
      dp <= '0;
      res_valid <= '0;
      res_quotient <= '0;
      res_tag <= '0;
    end else begin
      state <= state_nxt;
      hcnt <= xfer ? '0 : hcnt + 1'b1;
      if (xfer) begin
        div_dividend <= req_dividend[gid*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
        div_divisor <= req_divisor[gid*DIVISOR_WIDTH +: DIVISOR_WIDTH];
        rr_ptr <= gid == IW'(NREQ - 1) ? '0 : gid + 1'b1;
      end
      dv <= {dv[LATENCY-1:0], xfer};
      dp <= {dp[LATENCY*PW-1:0], gid, req_tag[gid*TAG_WIDTH +: TAG_WIDTH]};
      res_valid <= dv[LATENCY] ? NREQ'(1) << out_p[PW-1 -: IW] : '0;
      if (dv[LATENCY]) begin
        res_quotient <= div_quotient;
        res_tag <= out_p[TAG_WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: randomized bench with a cycle-level reference model of grants, operand hold and result return
module tb_div_arbiter;
  localparam int N  = 2;
  localparam int DW = 17;
  localparam int SW = 13;
  localparam int QW = 18;
  localparam int TW = 4;
  localparam int II = 4;
  localparam int L  = 5;
  localparam int M  = II > L + 2 ? II : L + 2;

  logic clk = 0, rst;
  logic [N-1:0] req_valid, req_ready, res_valid;
  logic [N*DW-1:0] req_dividend;
  logic [N*SW-1:0] req_divisor;
  logic [N*TW-1:0] req_tag;
  logic [DW-1:0] div_dividend;
  logic [SW-1:0] div_divisor;
  logic [QW-1:0] div_quotient, res_quotient;
  logic [TW-1:0] res_tag;
  logic busy;

  div_arbiter #(.NREQ(N), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(SW), .QUOTIENT_WIDTH(QW),
                .TAG_WIDTH(TW), .ISSUE_INTERVAL(II), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .req_tag(req_tag),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_quotient(div_quotient),
    .res_valid(res_valid), .res_quotient(res_quotient), .res_tag(res_tag), .busy(busy));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // s.10.6 quotient of the raw operands, as the external divider produces it
  function automatic logic [QW-1:0] divf(input logic [DW-1:0] dd, input logic [SW-1:0] ds);
    int n, d;
    n = int'($signed(dd)) * 64;
    d = int'($signed(ds));
    return d == 0 ? '0 : QW'(n / d);
  endfunction

  logic [QW-1:0] pipe [L] = '{default: '0};
  always @(posedge clk) begin
    pipe[0] <= divf(div_dividend, div_divisor);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign div_quotient = pipe[L-1];

  typedef struct {int due; int id; logic [TW-1:0] tag; logic [QW-1:0] q;} res_t;
  res_t sb[$];
  int cyc = 0, free_at = 0, rr = 0, last_t = 0, eg;
  bit have_last = 0;
  logic [DW-1:0] exp_dd = '0;
  logic [SW-1:0] exp_ds = '0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_ready", 32'(req_ready), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_div_dividend", 32'(div_dividend), 0);
      check("rst_div_divisor", 32'(div_divisor), 0);
      check("rst_res_quotient", 32'(res_quotient), 0);
      check("rst_res_tag", 32'(res_tag), 0);
      sb.delete();
      free_at = 0;
      rr = 0;
      have_last = 0;
      exp_dd = '0;
      exp_ds = '0;
    end else begin
      eg = -1;
      if (cyc >= free_at)
        for (int k = 0; k < N; k++)
          if (eg < 0 && req_valid[(rr + k) % N]) eg = (rr + k) % N;
      check("ready", 32'(req_ready), eg < 0 ? 0 : 1 << eg);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("res_valid", 32'(res_valid), 1 << sb[0].id);
        check("res_quotient", 32'(res_quotient), 32'(sb[0].q));
        check("res_tag", 32'(res_tag), 32'(sb[0].tag));
        void'(sb.pop_front());
      end else check("res_idle", 32'(res_valid), 0);
      check("busy", 32'(busy), 32'(have_last && cyc >= last_t + 1 && cyc <= last_t + M));
      check("div_dividend", 32'(div_dividend), 32'(exp_dd));
      check("div_divisor", 32'(div_divisor), 32'(exp_ds));
      if (eg >= 0) begin
        exp_dd = req_dividend[eg*DW +: DW];
        exp_ds = req_divisor[eg*SW +: SW];
        sb.push_back('{cyc + L + 2, eg, req_tag[eg*TW +: TW], divf(exp_dd, exp_ds)});
        rr = (eg + 1) % N;
        free_at = cyc + II;
        have_last = 1;
        last_t = cyc;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_ops();
    for (int i = 0; i < N; i++) begin
      req_dividend[i*DW +: DW] = DW'($urandom);
      req_divisor[i*SW +: SW] = SW'($urandom_range(1, (1 << SW) - 1));
      req_tag[i*TW +: TW] = TW'($urandom);
    end
  endtask

  task automatic set_op(input int i, input int dd, input int ds, input int tag);
    req_dividend[i*DW +: DW] = DW'(dd);
    req_divisor[i*SW +: SW] = SW'(ds);
    req_tag[i*TW +: TW] = TW'(tag);
  endtask

  initial begin
    rst = 1;
    req_valid = N'($urandom);
    rnd_ops();
    repeat (5) begin
      step();
      req_valid = N'($urandom);
      rnd_ops();
    end
    rst = 0;
    req_valid = '0;
    repeat (20) step();
    req_valid = 2'b01;
    set_op(0, 6, 3, 5);
    step();
    req_valid = '0;
    req_dividend[0 +: DW] = DW'(100);
    repeat (6) step();
    check("single_valid", 32'(res_valid), 1);
    check("single_quotient", 32'(res_quotient), 128);
    check("single_tag", 32'(res_tag), 5);
    repeat (5) step();
    req_valid = 2'b11;
    repeat (40) begin
      rnd_ops();
      step();
    end
    req_valid = '0;
    repeat (10) step();
    req_valid = 2'b10;
    repeat (16) begin
      rnd_ops();
      step();
    end
    req_valid = '0;
    repeat (10) step();
    req_valid = 2'b01;
    rnd_ops();
    step();
    req_valid = '0;
    repeat (2) step();
    rst = 1;
    step();
    rst = 0;
    repeat (12) step();
    req_valid = 2'b11;
    rnd_ops();
    step();
    req_valid = '0;
    repeat (12) step();
    repeat (600) begin
      req_valid = N'($urandom);
      rnd_ops();
      rst = $urandom_range(0, 99) == 0;
      step();
    end
    rst = 0;
    req_valid = '0;
    repeat (12) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
